// File: rtl/line_window_pkg.sv
// Shared definitions for the line-window sequencer: default geometry,
// controller state encoding and the buffer-geometry sanity check.
package line_window_pkg;

    localparam int LW_DATA_W = 32;   // pixel word width
    localparam int LW_ADDR_W = 7;    // shift-memory address width
    localparam int LW_ROW_W  = 35;   // words per image row
    localparam int LW_DEPTH  = 71;   // words in use: two rows plus one

    typedef enum logic [2:0] {
        IDLE,
        RD1,
        RD2,
        WR,
        OUT
    } lw_state_e;

    // The ring only lines up row-for-row when it holds exactly two rows plus
    // the slot being written.
    function automatic bit depth_ok(int row_w, int depth);
        return depth == 2 * row_w + 1;
    endfunction

endpackage

// File: rtl/line_window_ctrl_if.sv
// Handshake and memory bus of the line-window sequencer.
// master: the surrounding system (pixel source, kernel sink, shift memory).
// slave : the sequencer itself.
interface line_window_ctrl_if
    import line_window_pkg::*;
#(
    parameter int DATA_W = LW_DATA_W,
    parameter int ADDR_W = LW_ADDR_W
) ();

    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_tap0;
    logic [DATA_W-1:0] out_tap1;
    logic [DATA_W-1:0] out_tap2;
    logic              out_primed;
    logic              mem_write_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic [DATA_W-1:0] mem_rd_data;

    modport master (
        output flush, in_valid, in_data, out_ready, mem_rd_data,
        input  in_ready, out_valid, out_tap0, out_tap1, out_tap2, out_primed,
               mem_write_en, mem_addr, mem_wr_data
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready, mem_rd_data,
        output in_ready, out_valid, out_tap0, out_tap1, out_tap2, out_primed,
               mem_write_en, mem_addr, mem_wr_data
    );

endinterface

// File: rtl/line_window_ctrl_ring_addr_sub.sv
// ring_addr_sub: combinational (base - OFFSET) mod DEPTH for a base that is
// already inside the ring. One extra sign bit detects the borrow; adding
// DEPTH back is done at ADDR_W bits, which is exact because the true result
// is always below DEPTH.
module ring_addr_sub
    import line_window_pkg::*;
#(
    parameter int ADDR_W = LW_ADDR_W,
    parameter int DEPTH  = LW_DEPTH,
    parameter int OFFSET = LW_ROW_W
) (
    input  logic [ADDR_W-1:0] base,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W:0] diff;

    assign diff = {1'b0, base} - (ADDR_W + 1)'(OFFSET);
    assign addr = diff[ADDR_W] ? (diff[ADDR_W-1:0] + ADDR_W'(DEPTH))
                               : diff[ADDR_W-1:0];

endmodule

// File: rtl/line_window_ctrl.sv
// line_window_ctrl: drives a single-port shift memory as a circular two-row
// line buffer. Each accepted pixel reads the same column one and two rows
// back, overwrites the oldest slot with the new pixel and presents a 3-tap
// vertical window (current, one row up, two rows up).
// Optional build macro LINE_WINDOW_PRIME_GATE_EN: while the buffer is not
// yet primed, pixels are stored but no window is emitted.
module line_window_ctrl
    import line_window_pkg::*;
#(
    parameter int DATA_W = LW_DATA_W,
    parameter int ADDR_W = LW_ADDR_W,
    parameter int ROW_W  = LW_ROW_W,
    parameter int DEPTH  = LW_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    line_window_ctrl_if.slave   bus
);

    if (!depth_ok(ROW_W, DEPTH)) begin : g_depth_chk
        $error("line_window_ctrl: DEPTH must equal 2*ROW_W+1");
    end

    lw_state_e         state;
    logic [ADDR_W-1:0] wp;          // next slot to overwrite
    logic [ADDR_W-1:0] fill;        // words written since reset/flush, saturating
    logic [DATA_W-1:0] pix;         // pixel being processed
    logic [DATA_W-1:0] t1;          // one-row-back word
    logic              z1;          // one-row-back tap not yet written
    logic              z2;          // two-rows-back tap not yet written
    logic [ADDR_W-1:0] a1;
    logic [ADDR_W-1:0] a2;
    logic              skip_out;

    logic              out_valid_r;
    logic [DATA_W-1:0] tap0_r;
    logic [DATA_W-1:0] tap1_r;
    logic [DATA_W-1:0] tap2_r;      // also serves as the two-rows-back capture
    logic              primed_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wd_r;

    ring_addr_sub #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .OFFSET(ROW_W)) u_a1 (
        .base (wp),
        .addr (a1)
    );

    ring_addr_sub #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .OFFSET(2 * ROW_W)) u_a2 (
        .base (wp),
        .addr (a2)
    );

`ifdef LINE_WINDOW_PRIME_GATE_EN
    assign skip_out = z2;
`else
    assign skip_out = 1'b0;
`endif

    // Ready only in IDLE; a flush in IDLE takes the cycle, so no pixel then.
    assign bus.in_ready     = (state == IDLE) && !bus.flush && !rst;
    assign bus.out_valid    = out_valid_r;
    assign bus.out_tap0     = tap0_r;
    assign bus.out_tap1     = tap1_r;
    assign bus.out_tap2     = tap2_r;
    assign bus.out_primed   = primed_r;
    assign bus.mem_write_en = mem_we_r;
    assign bus.mem_addr     = mem_addr_r;
    assign bus.mem_wr_data  = mem_wd_r;

    // Sequencer: accept, read row-1, read row-2, write, present window.
    // Memory outputs are registered one state ahead so the address is on the
    // bus for the whole state that needs it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wp          <= '0;
            fill        <= '0;
            pix         <= '0;
            t1          <= '0;
            z1          <= 1'b0;
            z2          <= 1'b0;
            out_valid_r <= 1'b0;
            tap0_r      <= '0;
            tap1_r      <= '0;
            tap2_r      <= '0;
            primed_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wd_r    <= '0;
        end else begin
            mem_we_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.flush) begin
                        wp       <= '0;
                        fill     <= '0;
                        primed_r <= 1'b0;
                    end else if (bus.in_valid) begin
                        pix        <= bus.in_data;
                        z1         <= (fill < ADDR_W'(ROW_W));
                        z2         <= (fill < ADDR_W'(2 * ROW_W));
                        mem_addr_r <= a1;
                        state      <= RD1;
                    end
                end
                RD1: begin
                    mem_addr_r <= a2;
                    state      <= RD2;
                end
                RD2: begin
                    t1         <= bus.mem_rd_data;
                    mem_addr_r <= wp;
                    mem_we_r   <= 1'b1;
                    mem_wd_r   <= pix;
                    state      <= WR;
                end
                WR: begin
                    wp         <= (wp == ADDR_W'(DEPTH - 1)) ? '0 : wp + ADDR_W'(1);
                    if (fill < ADDR_W'(2 * ROW_W))
                        fill <= fill + ADDR_W'(1);
                    primed_r   <= (fill >= ADDR_W'(2 * ROW_W - 1));
                    mem_addr_r <= '0;
                    tap0_r     <= pix;
                    tap1_r     <= z1 ? '0 : t1;
                    tap2_r     <= z2 ? '0 : bus.mem_rd_data;
                    if (skip_out) begin
                        state <= IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                        state       <= OUT;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_window_ctrl.sv
// Scoreboard bench for line_window_ctrl. The reference model keeps the full
// history of pixels written since the last reset/flush and derives each
// window and each expected memory write from plain index arithmetic.
module tb_line_window_ctrl;
    import line_window_pkg::*;

    localparam int DW  = LW_DATA_W;
    localparam int AW  = LW_ADDR_W;
    localparam int ROW = LW_ROW_W;
    localparam int DEP = LW_DEPTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    line_window_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    line_window_ctrl #(.DATA_W(DW), .ADDR_W(AW), .ROW_W(ROW), .DEPTH(DEP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [DW-1:0] t0;
        logic [DW-1:0] t1;
        logic [DW-1:0] t2;
        logic          primed;
        int            cyc;
    } win_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    win_t          eq[$];
    wr_t           wq[$];
    logic [DW-1:0] hist[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 0;
    bit rnd_or = 0;
    bit or_fixed = 1;

    task automatic chk(string name, logic [95:0] act, logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(string name);
        checks++;
        errors++;
        $display("FAIL %s: got no event expected one within bound", name);
    endtask

    // Shift memory: synchronous read, data one cycle after the address.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    bit mem_init = 0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= $urandom;
            mem_init <= 1'b1;
        end else begin
            if (bus.mem_write_en) mem[bus.mem_addr] <= bus.mem_wr_data;
            bus.mem_rd_data <= mem[bus.mem_addr];
        end
    end

    // Downstream ready: fixed or random.
    always @(negedge clk)
        bus.out_ready = rnd_or ? ($urandom_range(0, 3) != 0) : or_fixed;

    // Monitor: pops expected writes and windows as the DUT presents them.
    bit   held   = 0;
    bit   prev_v = 0;
    win_t cur;
    always @(posedge clk) begin
        cyc++;
        #1;
        if (!mon_en || rst) begin
            held   = 0;
            prev_v = 0;
        end else begin
            if (prev_v && bus.out_ready) held = 0;
            if (bus.mem_write_en) begin
                if (wq.size() == 0) fail("unexpected_write");
                else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("mem_write", {bus.mem_addr, bus.mem_wr_data}, {w.addr, w.data});
                end
            end
            if (bus.out_valid) begin
                if (!held) begin
                    held = 1;
                    if (eq.size() == 0) fail("unexpected_window");
                    else begin
                        cur = eq.pop_front();
                        chk("latency", 96'(cyc), 96'(cur.cyc + 4));
                        chk("primed", bus.out_primed, cur.primed);
                    end
                end
                chk("window", {bus.out_tap0, bus.out_tap1, bus.out_tap2},
                    {cur.t0, cur.t1, cur.t2});
                chk("busy_in_out", {bus.in_ready, bus.mem_write_en}, '0);
            end
            prev_v = bus.out_valid;
        end
    end

    // Offer one pixel, wait for acceptance, update the reference model.
    task automatic push(logic [DW-1:0] d);
        int   n;
        int   k;
        win_t w;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        k = 0;
        #1;
        while (!bus.in_ready && k < 300) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (!bus.in_ready) begin
            fail("accept_timeout");
            bus.in_valid = 1'b0;
            return;
        end
        n = hist.size();
        w.t0     = d;
        w.t1     = (n >= ROW)     ? hist[n - ROW]     : '0;
        w.t2     = (n >= 2 * ROW) ? hist[n - 2 * ROW] : '0;
        w.primed = (n + 1 >= 2 * ROW);
        w.cyc    = cyc;
`ifdef LINE_WINDOW_PRIME_GATE_EN
        if (n >= 2 * ROW) eq.push_back(w);
`else
        eq.push_back(w);
`endif
        wq.push_back('{addr: AW'(n % DEP), data: d});
        hist.push_back(d);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((eq.size() != 0 || wq.size() != 0 || !bus.in_ready) && k < 500) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("drain_empty", 96'(eq.size() + wq.size()), '0);
    endtask

    initial begin
        int k;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.flush    = 1'b0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_ctrl", {bus.in_ready, bus.out_valid, bus.out_primed,
                           bus.mem_write_en, bus.mem_addr}, '0);
        chk("reset_taps", {bus.out_tap0, bus.out_tap1, bus.out_tap2}, '0);
        chk("reset_wdata", bus.mem_wr_data, '0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", bus.in_ready, 1'b1);
        mon_en = 1;

        // Reset while the controller sits in RD2: pixel dropped, no write.
        push(32'hDEAD_BEEF);
        @(negedge clk);
        mon_en = 0;
        rst    = 1'b1;
        #1;
        chk("midseq_reset_ctrl", {bus.in_ready, bus.out_valid, bus.out_primed,
                                  bus.mem_write_en, bus.mem_addr}, '0);
        repeat (2) begin
            @(negedge clk);
            chk("midseq_reset_we", bus.mem_write_en, 1'b0);
        end
        eq.delete();
        wq.delete();
        hist.delete();
        rst = 1'b0;
        #1;
        chk("ready_after_midseq", bus.in_ready, 1'b1);
        mon_en = 1;

        // Fill, first full window and wrap-around.
        or_fixed = 1;
        for (int i = 1; i <= 73; i++) push(DW'(i));
        drain();
        chk("primed_full", bus.out_primed, 1'b1);

        // Backpressure: window held with no memory traffic.
        or_fixed = 0;
        push($urandom);
        k = 0;
        while (!bus.out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!bus.out_valid) fail("bp_window");
        repeat (10) @(negedge clk);
        chk("bp_hold", {bus.out_valid, bus.in_ready}, 2'b10);
        or_fixed = 1;
        drain();

        // Flush beats a simultaneous valid pixel.
        @(negedge clk);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hF1F1_F1F1;
        #1;
        chk("flush_ready", bus.in_ready, 1'b0);
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("flush_primed", bus.out_primed, 1'b0);
        hist.delete();
        repeat (3) @(negedge clk);

        // Random traffic with random backpressure; wraps the ring repeatedly.
        rnd_or = 1;
        for (int i = 0; i < 160; i++) begin
            push($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        rnd_or = 0;
        or_fixed = 1;
        drain();
        chk("primed_end", bus.out_primed, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

endmodule
